// File: rtl/mmio_axil_defs.sv
// rtl/mmio_axil_defs.sv - shared state encodings and AXI response codes for the MMIO AXI-Lite master
package mmio_axil_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    // The watchdog reuses the DECERR code so a stuck slave looks like a decode failure upstream.
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

endpackage

// File: rtl/mmio_axil_watchdog.sv
// rtl/mmio_axil_watchdog.sv - transaction watchdog, only built when MMIO_AXIL_TIMEOUT_EN is defined
//  fclk, rst_n : clock, asynchronous active-low reset
//  clr         : zero the counter (request accepted)
//  en          : count this cycle (transaction outstanding)
//  expired     : the LIMIT-th outstanding cycle is now
`ifdef MMIO_AXIL_TIMEOUT_EN
module mmio_axil_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter holds k-1 in the k-th outstanding cycle, so expiry fires in cycle LIMIT and the
    // response is presented one cycle later.
    assign expired = en && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mmio_axil_master.sv
// rtl/mmio_axil_master.sv - single-outstanding AXI4-Lite initiator driven by a local request/response port
//  Request  : req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb
//  Response : rsp_valid/rsp_ready/rsp_rdata/rsp_resp, busy
//  AXI side : M_AXI_AW*, M_AXI_W*, M_AXI_B*, M_AXI_AR*, M_AXI_R*
//  Option   : MMIO_AXIL_TIMEOUT_EN adds a watchdog that ends a stuck transaction with resp 2'b11
module mmio_axil_master
    import mmio_axil_defs::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                fclk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                busy,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                ar_done_q, ar_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                accept;
    logic                wd_expired;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    // VALIDs are derived from state plus per-channel done flags, so leaving WR/RD (response or
    // watchdog) and reset both drop them without extra flops.
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = (state_q == ST_WR) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = (state_q == ST_WR) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == ST_WR);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = (state_q == ST_RD) && !ar_done_q;
    assign M_AXI_RREADY  = (state_q == ST_RD) && ar_done_q;

`ifdef MMIO_AXIL_TIMEOUT_EN
    mmio_axil_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .fclk    (fclk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      ((state_q == ST_WR) || (state_q == ST_RD)),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ar_done_d = ar_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    state_d   = req_write ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
                // A B handshake in the expiry cycle has really happened, so the slave code wins.
                if (M_AXI_BVALID) begin
                    rdata_d = '0;
                    resp_d  = M_AXI_BRESP;
                    state_d = ST_RSP;
                end else if (wd_expired) begin
                    rdata_d = '0;
                    resp_d  = RESP_TIMEOUT;
                    state_d = ST_RSP;
                end
            end
            ST_RD: begin
                if (M_AXI_ARVALID && M_AXI_ARREADY) ar_done_d = 1'b1;
                if (M_AXI_RVALID && M_AXI_RREADY) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = ST_RSP;
                end else if (wd_expired) begin
                    rdata_d = '0;
                    resp_d  = RESP_TIMEOUT;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

endmodule

// File: tb/tb_mmio_axil_master.sv
// tb/tb_mmio_axil_master.sv - scoreboard bench for mmio_axil_master against a behavioural AXI-Lite slave
module tb_mmio_axil_master;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 fclk = ~fclk;

    mmio_axil_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .fclk(fclk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%h exp=0x%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural slave: 32 words at 0x00-0x7C, SLVERR beyond ----------------
    logic [31:0] mem [32];
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          silent = 1'b0;
    int          aw_wait, w_wait, ar_wait;
    logic        aw_got, w_got;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] wa, wd;
    logic [3:0]  ws;

    assign awready = awvalid && !silent && (aw_wait >= aw_delay);
    assign wready  = wvalid  && !silent && (w_wait  >= w_delay);
    assign arready = arvalid && !silent && (ar_wait >= ar_delay);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready)   ? w_wait + 1  : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; s_awaddr <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                wa = (awvalid && awready) ? awaddr : s_awaddr;
                wd = (wvalid && wready) ? wdata : s_wdata;
                ws = (wvalid && wready) ? wstrb : s_wstrb;
                if (wa < 32'h80) begin
                    mem[wa[6:2]] <= merge(mem[wa[6:2]], wd, ws);
                    bresp <= 2'b00;
                end else begin
                    bresp <= 2'b10;
                end
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
            end else if (arvalid && arready) begin
                rvalid <= 1'b1;
                if (araddr < 32'h80) begin rdata <= mem[araddr[6:2]]; rresp <= 2'b00; end
                else begin rdata <= 32'h0; rresp <= 2'b10; end
            end
        end
    end

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    int          cyc = 0;
    int          acc_cyc, aw_rel, w_rel, rsp_rel, b_cnt, ar_stall, hold_cnt;
    logic        prev_rsp_pend = 1'b0, prev_ar_pend = 1'b0;
    logic [31:0] prev_rdata, prev_araddr;
    logic [1:0]  prev_resp;
    exp_t        e;

    always @(posedge fclk) cyc <= cyc + 1;

    always @(negedge fclk) begin
        if (!rst_n) begin
            prev_rsp_pend = 1'b0;
            prev_ar_pend  = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc; aw_rel = -1; w_rel = -1; rsp_rel = -1;
                b_cnt = 0; ar_stall = 0; hold_cnt = 0;
            end
            if (awvalid && awready) aw_rel = cyc - acc_cyc;
            if (wvalid && wready)   w_rel  = cyc - acc_cyc;
            if (bvalid && bready)   b_cnt++;
            if (prev_ar_pend) begin
                chk("arvalid_held", 32'(arvalid), 32'd1);
                chk("araddr_stable", araddr, prev_araddr);
            end
            if (arvalid && !arready) ar_stall++;
            prev_ar_pend = arvalid && !arready;
            prev_araddr  = araddr;
            if (rsp_valid && rsp_rel < 0) rsp_rel = cyc - acc_cyc;
            if (prev_rsp_pend) begin
                chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
                chk("rsp_rdata_stable", rsp_rdata, prev_rdata);
                chk("rsp_resp_stable", 32'(rsp_resp), 32'(prev_resp));
                chk("req_ready_low_in_rsp", 32'(req_ready), 32'd0);
            end
            if (rsp_valid && !rsp_ready) hold_cnt++;
            prev_rsp_pend = rsp_valid && !rsp_ready;
            prev_rdata    = rsp_rdata;
            prev_resp     = rsp_resp;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        while (!req_ready && n < 50) begin @(posedge fclk); #1; n++; end
        if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
        @(posedge fclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        int n = 0;
        while (!rsp_valid && n < 100) begin @(posedge fclk); #1; n++; end
        if (!rsp_valid) begin
            chk("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
        end else begin
            repeat (hold) begin @(posedge fclk); #1; end
            rsp_ready = 1'b1;
            @(posedge fclk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_resp, input int hold);
        sb.push_back('{exp_rdata, exp_resp});
        issue(wr, a, d, s);
        collect(hold);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0100_0000 + i;
        mem[4]  = 32'h1122_3344;
        mem[16] = 32'h1234_5678;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge fclk);
        #1 rst_n = 1'b1;
        @(posedge fclk); #1;

        // reset state
        chk("reset_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_resp", 32'(rsp_resp), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // zero-wait write 0x8 <- DEADBEEF
        txn(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 0);
        chk("wr0_aw_cycle", 32'(aw_rel), 32'd1);
        chk("wr0_w_cycle", 32'(w_rel), 32'd1);
        chk("wr0_rsp_cycle", 32'(rsp_rel), 32'd3);
        chk("wr0_b_count", 32'(b_cnt), 32'd1);
        chk("wr0_slave_reg2", mem[2], 32'hDEAD_BEEF);

        // read back register 2
        txn(1'b0, 32'h8, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 0);
        chk("rd0_rsp_cycle", 32'(rsp_rel), 32'd3);

        // read 0x40 with 5-cycle ARREADY stall
        ar_delay = 5;
        txn(1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0);
        chk("rd_stall_cycles", 32'(ar_stall), 32'd5);
        ar_delay = 0;

        // write with WREADY 3 cycles after AWREADY, partial strobes
        w_delay = 3;
        txn(1'b1, 32'h10, 32'hA5A5_0000, 4'b1100, 32'h0, 2'b00, 0);
        chk("wr_late_aw_cycle", 32'(aw_rel), 32'd1);
        chk("wr_late_w_cycle", 32'(w_rel), 32'd4);
        chk("wr_late_b_count", 32'(b_cnt), 32'd1);
        chk("wr_late_rsp_cycle", 32'(rsp_rel), 32'd6);
        chk("wr_late_slave_reg4", mem[4], 32'hA5A5_3344);
        w_delay = 0;

        // out-of-range read -> SLVERR
        txn(1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 2'b10, 0);
        chk("slverr_busy_after", 32'(busy), 32'd0);
        chk("slverr_req_ready_after", 32'(req_ready), 32'd1);

        // response back-pressure for 10 cycles
        txn(1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 10);
        chk("hold_cycles", 32'(hold_cnt), 32'd10);

        // asynchronous reset in the middle of a write to a silent slave
        silent = 1'b1;
        issue(1'b1, 32'h20, 32'h5555_AAAA, 4'hF);
        repeat (2) @(posedge fclk);
        #3;
        chk("midwr_awvalid_before", 32'(awvalid), 32'd1);
        chk("midwr_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwr_valids_after", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
        chk("midwr_busy_after", 32'(busy), 32'd0);
        @(posedge fclk); #1;
        rst_n = 1'b1;
        silent = 1'b0;
        chk("midwr_reg8_untouched", mem[8], 32'h0100_0008);

        // transaction after the reset completes normally
        txn(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, 0);
        chk("post_reset_reg8", mem[8], 32'hCAFE_F00D);

`ifdef MMIO_AXIL_TIMEOUT_EN
        silent = 1'b1;
        txn(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 2'b11, 0);
        chk("timeout_rsp_cycle", 32'(rsp_rel), 32'd17);
        silent = 1'b0;
        txn(1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0);
`endif

        repeat (2) @(posedge fclk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
